// File: rtl/cordic_phase_gen.sv
// Phase accumulator (NCO / linear chirp) feeding the angle input of the CORDIC stage.
// Optional angle dither, enabled by defining CORDIC_PHASE_DITHER_EN.
module cordic_phase_gen #(
    parameter int BITS        = 16,
    parameter int LAT         = 2,
    parameter int CNT_W       = 16,
    parameter int DITHER_BITS = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic signed [BITS:0]   cfg_phase0,
    input  logic signed [BITS:0]   cfg_ftw,
    input  logic signed [BITS:0]   cfg_dftw,
    input  logic [CNT_W-1:0]       cfg_nsteps,
    input  logic                   run_en,
    input  logic                   stop,
    output logic signed [BITS:0]   angle,
    output logic                   angle_valid,
    output logic                   sample_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int SW = BITS + 3;
    localparam logic signed [SW-1:0] PI     = SW'(51472);
    localparam logic signed [SW-1:0] TWO_PI = SW'(102944);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    function automatic logic signed [SW-1:0] ext(input logic signed [BITS:0] x);
        return {{2{x[BITS]}}, x};
    endfunction

    function automatic logic signed [BITS:0] sat_f(input logic signed [SW-1:0] x);
        logic signed [SW-1:0] y;
        if (x > PI)
            y = PI;
        else if (x < -PI)
            y = -PI;
        else
            y = x;
        return y[BITS:0];
    endfunction

    // Exactly +/-PI is a legal angle and passes through untouched.
    function automatic logic signed [BITS:0] wrap_f(input logic signed [SW-1:0] x);
        logic signed [SW-1:0] y;
        if (x > PI)
            y = x - TWO_PI;
        else if (x < -PI)
            y = x + TWO_PI;
        else
            y = x;
        return y[BITS:0];
    endfunction

    state_t                 r_state;
    logic signed [BITS:0]   r_acc;
    logic signed [BITS:0]   r_ftw;
    logic signed [BITS:0]   r_dftw;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_done;
    logic [LAT-1:0]         r_sv;

    logic                   w_run;
    logic signed [BITS:0]   w_acc_next;
    logic signed [BITS:0]   w_ftw_next;
    logic signed [BITS:0]   w_phase0_sat;
    logic signed [BITS:0]   w_ftw_load_sat;

    assign w_run          = (r_state == S_RUN);
    assign w_acc_next     = wrap_f(ext(r_acc) + ext(r_ftw));
    assign w_ftw_next     = sat_f(ext(r_ftw) + ext(r_dftw));
    assign w_phase0_sat   = sat_f(ext(cfg_phase0));
    assign w_ftw_load_sat = sat_f(ext(cfg_ftw));

    assign busy         = w_run;
    assign cfg_ready    = ~w_run;
    assign angle_valid  = w_run & run_en;
    assign done         = r_done;
    assign sample_valid = r_sv[LAT-1];

    // acc is not advanced on the final sample or on stop, so it doubles as
    // the held angle while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_ftw   <= '0;
            r_dftw  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        r_acc   <= w_phase0_sat;
                        r_ftw   <= w_ftw_load_sat;
                        r_dftw  <= cfg_dftw;
                        r_cnt   <= cfg_nsteps;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                    end else if (run_en) begin
                        r_ftw <= w_ftw_next;
                        if (r_cnt == CNT_W'(1)) begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_acc <= w_acc_next;
                            if (r_cnt != '0)
                                r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Not flushed by stop: samples already inside the CORDIC still complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sv <= '0;
        end else begin
            r_sv[0] <= angle_valid;
            for (int i = 1; i < LAT; i++)
                r_sv[i] <= r_sv[i-1];
        end
    end

    if (DITHER_BITS < 1 || DITHER_BITS > 16) begin : g_dither_bits_range
        $error("DITHER_BITS must be within 1..16");
    end

`ifdef CORDIC_PHASE_DITHER_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_lfsr <= 16'hACE1;
        else if (angle_valid)
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    assign angle = wrap_f(ext(r_acc) + $signed({{(SW-DITHER_BITS){1'b0}}, r_lfsr[DITHER_BITS-1:0]}));
`else
    assign angle = r_acc;
`endif

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Self-checking bench for cordic_phase_gen: directed sequences plus randomized
// configurations with random stalls, compared against an integer model.
module tb_cordic_phase_gen;

    localparam int BITS  = 16;
    localparam int LAT   = 2;
    localparam int CNT_W = 16;
    localparam int PI    = 51472;
    localparam int TWOPI = 102944;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic signed [BITS:0] cfg_phase0;
    logic signed [BITS:0] cfg_ftw;
    logic signed [BITS:0] cfg_dftw;
    logic [CNT_W-1:0]     cfg_nsteps;
    logic                 run_en;
    logic                 stop;
    logic signed [BITS:0] angle;
    logic                 angle_valid;
    logic                 sample_valid;
    logic                 busy;
    logic                 done;

    int n_pass  = 0;
    int n_total = 0;
    int exp_q[$];

    cordic_phase_gen #(.BITS(BITS), .LAT(LAT), .CNT_W(CNT_W), .DITHER_BITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_phase0(cfg_phase0), .cfg_ftw(cfg_ftw), .cfg_dftw(cfg_dftw),
        .cfg_nsteps(cfg_nsteps), .run_en(run_en), .stop(stop), .angle(angle),
        .angle_valid(angle_valid), .sample_valid(sample_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_m(input int x);
        return (x > PI) ? PI : ((x < -PI) ? -PI : x);
    endfunction

    function automatic int wrap_m(input int x);
        return (x > PI) ? x - TWOPI : ((x < -PI) ? x + TWOPI : x);
    endfunction

    // Expected angle sequence from the phase/frequency rules, independent of timing.
    function automatic void model(input int p0, input int f, input int d, input int n);
        int acc, ftw;
        exp_q.delete();
        acc = sat_m(p0);
        ftw = sat_m(f);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(acc);
            acc = wrap_m(acc + ftw);
            ftw = sat_m(ftw + d);
        end
    endfunction

    task automatic load(input int p0, input int f, input int d, input int n);
        cyc();
        cfg_phase0 = p0[BITS:0];
        cfg_ftw    = f[BITS:0];
        cfg_dftw   = d[BITS:0];
        cfg_nsteps = n[CNT_W-1:0];
        cfg_valid  = 1'b1;
        run_en     = 1'b1;
    endtask

    // Runs one complete sequence of n samples against exp_q, optionally with random stalls.
    task automatic run_seq(input string tag, input int p0, input int f, input int d,
                           input int n, input bit stalls);
        bit ev[0:255];
        int emitted;
        int i;
        bit r;
        load(p0, f, d, n);
        emitted = 0;
        i = 0;
        while (emitted < n && i < 200) begin
            cyc();
            cfg_valid = 1'b0;
            r = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
            run_en = r;
            ev[i] = r;
            @(negedge clk);
            chk({tag, " angle"}, angle, exp_q[emitted]);
            chk({tag, " angle_valid"}, angle_valid, r);
            chk({tag, " busy"}, busy, 1);
            chk({tag, " sample_valid"}, sample_valid, (i >= LAT) ? ev[i-LAT] : 0);
            if (r) emitted++;
            i++;
        end
        if (emitted < n) chk({tag, " timeout samples"}, emitted, n);
        cyc();
        run_en = 1'b1;
        ev[i] = 1'b0;
        @(negedge clk);
        chk({tag, " done pulse"}, done, 1);
        chk({tag, " busy end"}, busy, 0);
        chk({tag, " cfg_ready end"}, cfg_ready, 1);
        chk({tag, " angle_valid end"}, angle_valid, 0);
        chk({tag, " angle hold"}, angle, exp_q[n-1]);
        chk({tag, " sample_valid end"}, sample_valid, ev[i-LAT]);
        i++;
        cyc();
        ev[i] = 1'b0;
        @(negedge clk);
        chk({tag, " done clear"}, done, 0);
        chk({tag, " sample_valid tail"}, sample_valid, ev[i-LAT]);
    endtask

    initial begin
        int p0, f, d, n;
        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_phase0 = '0;
        cfg_ftw    = '0;
        cfg_dftw   = '0;
        cfg_nsteps = '0;
        run_en     = 1'b0;
        stop       = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset angle", angle, 0);
        chk("reset angle_valid", angle_valid, 0);
        chk("reset sample_valid", sample_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset cfg_ready", cfg_ready, 1);

        exp_q = '{0, 4096, 8192, 12288, 16384};
        run_seq("tone", 0, 4096, 0, 5, 1'b0);
        exp_q = '{51000, -50944, -49944};
        run_seq("poswrap", 51000, 1000, 0, 3, 1'b0);
        exp_q = '{-51472, 49472};
        run_seq("negsat", -60000, -2000, 0, 2, 1'b0);
        exp_q = '{0, 100, 250, 450};
        run_seq("chirp", 0, 100, 50, 4, 1'b0);
        exp_q = '{50472, 51472, -50472};
        run_seq("exact_pi", 50472, 1000, 0, 3, 1'b0);
        exp_q = '{7};
        run_seq("single", 7, 3, 0, 1, 1'b1);

        for (int t = 0; t < 8; t++) begin
            p0 = int'($urandom_range(0, 131071)) - 65536;
            f  = int'($urandom_range(0, 131071)) - 65536;
            d  = int'($urandom_range(0, 8000)) - 4000;
            n  = int'($urandom_range(1, 10));
            model(p0, f, d, n);
            run_seq($sformatf("rand%0d", t), p0, f, d, n, 1'b1);
        end

        // free-running tone, stall, then stop
        load(0, 1000, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            cfg_valid = 1'b0;
            @(negedge clk);
            chk("free angle", angle, k * 1000);
            chk("free angle_valid", angle_valid, 1);
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            run_en = 1'b0;
            @(negedge clk);
            chk("stall angle", angle, 4000);
            chk("stall angle_valid", angle_valid, 0);
            chk("stall busy", busy, 1);
        end
        cyc();
        run_en = 1'b1;
        @(negedge clk);
        chk("resume angle", angle, 4000);
        chk("resume angle_valid", angle_valid, 1);
        cyc();
        stop = 1'b1;
        @(negedge clk);
        chk("stop angle", angle, 5000);
        cyc();
        stop = 1'b0;
        @(negedge clk);
        chk("stop busy", busy, 0);
        chk("stop done", done, 0);
        chk("stop cfg_ready", cfg_ready, 1);
        chk("stop angle hold", angle, 5000);
        chk("stop angle_valid", angle_valid, 0);

        // stop coinciding with the final sample suppresses done
        load(0, 10, 0, 2);
        cyc();
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("laststop angle0", angle, 0);
        cyc();
        stop = 1'b1;
        @(negedge clk);
        chk("laststop angle1", angle, 10);
        chk("laststop angle_valid", angle_valid, 1);
        cyc();
        stop = 1'b0;
        @(negedge clk);
        chk("laststop done", done, 0);
        chk("laststop busy", busy, 0);
        cyc();
        @(negedge clk);
        chk("laststop done later", done, 0);

        // config while busy is ignored, then async reset mid-run
        load(0, 1000, 0, 0);
        cyc();
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("busycfg angle0", angle, 0);
        cyc();
        cfg_valid  = 1'b1;
        cfg_phase0 = 17'sd7777;
        @(negedge clk);
        chk("busycfg angle1", angle, 1000);
        chk("busycfg cfg_ready", cfg_ready, 0);
        cyc();
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("busycfg angle2", angle, 2000);
        chk("busycfg busy", busy, 1);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("async angle", angle, 0);
        chk("async angle_valid", angle_valid, 0);
        chk("async sample_valid", sample_valid, 0);
        chk("async busy", busy, 0);
        chk("async done", done, 0);
        cyc();
        rst_n = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        chk("idle stop busy", busy, 0);
        cyc();
        stop = 1'b0;
        @(negedge clk);
        chk("idle stop busy later", busy, 0);
        chk("idle stop cfg_ready", cfg_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cordic_phase_gen.md
Name: cordic_phase_gen

Overview:
Phase-accumulator (NCO/chirp) front end driving the angle input of the pipelined CORDIC sin/cos stage. Produces one signed angle per enabled cycle, wrapped to [-PI, +PI], in the same fixed-point format: 17-bit signed, 14 fractional bits, PI = 51472.
Supports constant-frequency and linear-chirp sequences of programmable length, loaded through a valid/ready config handshake. Also emits a valid flag delayed to line up with the CORDIC outputs.

Parameters:
BITS, 16, magnitude width; angle/ftw/phase ports are BITS+1 signed.
LAT, 2, CORDIC latency in cycles (angle sampled -> sinus/cosinus registered); depth of sample_valid delay line.
CNT_W, 16, width of the sample-count field.
DITHER_BITS, 2, LSBs of dither added when the optional feature is compiled in.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  config request
cfg_ready  out  1  high only in IDLE
cfg_phase0  in  BITS+1  signed start phase
cfg_ftw  in  BITS+1  signed start phase increment per sample
cfg_dftw  in  BITS+1  signed increment added to ftw per sample (chirp); 0 = constant tone
cfg_nsteps  in  CNT_W  samples to emit; 0 = free-running until stop
run_en  in  1  stall control; low freezes all RUN state
stop  in  1  abort to IDLE
angle  out  BITS+1  signed angle to CORDIC
angle_valid  out  1  angle is a new sample this cycle
sample_valid  out  1  angle_valid delayed LAT cycles (CORDIC output valid)
busy  out  1  state == RUN
done  out  1  one-cycle pulse on natural completion

Behaviour:
- Reset (async, rst_n low): state IDLE; acc, ftw_r, cnt = 0; angle = 0; angle_valid, sample_valid, busy, done = 0; delay line cleared; cfg_ready = 1 after reset release.
- Constants: PI = 51472, 2PI = 102944. Internal sum width BITS+3 signed; no overflow possible.
- sat(x): clamp to [-PI, +PI]. Applied to cfg_phase0 and cfg_ftw on load, and to ftw_r after each chirp update.
- wrap(x): if x > PI then x - 2PI; else if x < -PI then x + 2PI; else x. Exactly ±PI is kept unchanged.
- States:
  - IDLE: on the cfg_valid & cfg_ready edge, acc <= sat(cfg_phase0), ftw_r <= sat(cfg_ftw), dftw_r <= cfg_dftw, cnt <= cfg_nsteps, state <= RUN. cfg_valid outside IDLE is ignored (not queued).
  - RUN: angle = acc (registered); angle_valid = run_en.
    - Each edge with run_en=1: acc <= wrap(acc + ftw_r); ftw_r <= sat(ftw_r + dftw_r).
    - If cnt != 0: cnt <= cnt - 1; when cnt == 1 the state becomes IDLE and done pulses on the next cycle.
    - cnt == 0 at load: runs indefinitely.
    - run_en=0: acc, ftw_r and cnt hold; angle holds its value; angle_valid = 0.
- First emitted sample is phase0, one cycle after the config accept. Exactly nsteps samples with angle_valid high.
- stop: takes priority in RUN. Next state is IDLE and done stays 0. If stop coincides with the final sample, that sample still counts as emitted, but done is suppressed. stop in IDLE has no effect.
- IDLE outputs: angle holds its last value; angle_valid = 0.
- sample_valid: shift register of angle_valid, LAT deep. It is not flushed by stop, so in-flight samples complete.
- busy is high for the same cycles as RUN; cfg_ready = ~busy.

Optional Feature:
Macro CORDIC_PHASE_DITHER_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances on every angle_valid cycle. Output angle = wrap(acc + lfsr[DITHER_BITS-1:0]); acc itself is never dithered.
- Undefined: no LFSR is built and angle = acc exactly.
- All Test Plan values below apply with the macro undefined.

Test Plan:
- Reset, then config phase0=0, ftw=4096, dftw=0, nsteps=5, run_en=1 -> angles 0, 4096, 8192, 12288, 16384 with angle_valid high for 5 cycles; done pulses once on the cycle after the last sample; sample_valid mirrors angle_valid 2 cycles later.
- Positive wrap: phase0=51000, ftw=1000, nsteps=3 -> angles 51000, -50944, -49944.
- Negative wrap and saturation: phase0=-60000, ftw=-2000, nsteps=2 -> angles -51472, -53472+102944 = 49472.
- Chirp: phase0=0, ftw=100, dftw=50, nsteps=4 -> angles 0, 100, 250, 450.
- Stall and stop: free-running ftw=1000. Drop run_en for 3 cycles -> angle frozen and angle_valid low. Then assert stop -> IDLE next cycle, done=0, cfg_ready=1.
- Busy config ignored and async reset: pulse cfg_valid during RUN -> no change. Assert rst_n low mid-run -> all outputs 0 immediately, without waiting for a clock edge.
